// File: rtl/spi_master_buffer_if.sv
// spi_master_buffer_if
// Parent-side handshake bundle for spi_master_buffer.
//   start  : single-cycle frame request (parent -> block)
//   length : byte count 1..4, 0 ignored, 5..7 clamp to 4 (parent -> block)
//   tx     : bytes to send, tx[0] first (parent -> block)
//   rx     : received bytes, rx[i] written when byte i completes (block -> parent)
//   busy   : frame in progress (block -> parent)
//   done   : one-cycle end-of-frame pulse (block -> parent)
// Modports: master = parent FSM side, slave = spi_master_buffer side.
interface spi_master_buffer_if;
   logic            start;
   logic [2:0]      length;
   logic [3:0][7:0] tx;
   logic [3:0][7:0] rx;
   logic            busy;
   logic            done;

   modport master (output start, output length, output tx,
                   input  rx,    input  busy,   input  done);
   modport slave  (input  start, input  length, input  tx,
                   output rx,    output busy,   output done);
endinterface

// File: rtl/spi_master_buffer.sv
// spi_master_buffer
// SPI initiator, mode 0, MSB first. Sends a 1..4 byte frame and captures
// the same number of response bytes. SCLK half-period = CLK_DIV clk cycles.
// Ports:
//   clk      : system clock, rising edge
//   reset    : asynchronous active-high reset; aborts any frame
//   bus      : parent handshake (start/length/tx in, rx/busy/done out)
//   spi_sclk : SPI clock, idles low
//   spi_cs_n : chip select, active low, idles high
//   spi_tx   : MOSI
//   spi_rx   : MISO, used unsynchronised
module spi_master_buffer #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   spi_master_buffer_if.slave    bus,
   output logic                  spi_sclk,
   output logic                  spi_cs_n,
   output logic                  spi_tx,
   input  logic                  spi_rx
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LEAD  = 3'd1;
   localparam logic [2:0] ST_HIGH  = 3'd2;
   localparam logic [2:0] ST_LOW   = 3'd3;
   localparam logic [2:0] ST_TRAIL = 3'd4;

   localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [2:0]      state_r;
   logic [CW-1:0]   cnt_r;
   logic            sclk_r;
   logic            cs_n_r;
   logic            mosi_r;
   logic            busy_r;
   logic            done_r;
   logic [3:0][7:0] rx_r;
   logic [3:0][7:0] tx_l_r;
   logic [7:0]      tx_sh_r;
   logic [7:0]      rx_sh_r;
   logic [2:0]      byte_r;
   logic [2:0]      bit_r;
   logic [2:0]      len_r;

   logic            wrap_s;
   logic            start_ok_s;
   logic [2:0]      len_eff_s;
   logic [2:0]      nxt_byte_s;

   assign wrap_s     = (cnt_r == CNT_LAST);
   assign start_ok_s = bus.start && (bus.length != 3'd0) && (state_r == ST_IDLE);
   assign nxt_byte_s = byte_r + 3'd1;

   // Clamp oversize byte counts to the four-byte buffer.
   always_comb begin
      len_eff_s = bus.length;
      if (bus.length > 3'd4) begin
         len_eff_s = 3'd4;
      end else begin
         len_eff_s = bus.length;
      end
   end

   // Half-period counter: every non-idle state lasts exactly CLK_DIV cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r <= CNT_ZERO;
      end else if ((state_r == ST_IDLE) || wrap_s) begin
         cnt_r <= CNT_ZERO;
      end else begin
         cnt_r <= cnt_r + CNT_ONE;
      end
   end

   // Frame sequencer; all SPI pins and handshake outputs are registered here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         cs_n_r  <= 1'b1;
         sclk_r  <= 1'b0;
         mosi_r  <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         rx_r    <= 32'h0;
         tx_l_r  <= 32'h0;
         tx_sh_r <= 8'h00;
         rx_sh_r <= 8'h00;
         byte_r  <= 3'd0;
         bit_r   <= 3'd0;
         len_r   <= 3'd0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start_ok_s) begin
                  state_r <= ST_LEAD;
                  cs_n_r  <= 1'b0;
                  busy_r  <= 1'b1;
                  tx_l_r  <= bus.tx;
                  tx_sh_r <= bus.tx[0];
                  mosi_r  <= bus.tx[0][7];
                  len_r   <= len_eff_s;
                  byte_r  <= 3'd0;
                  bit_r   <= 3'd0;
               end
            end
            ST_LEAD, ST_LOW: begin
               // Rising SCLK: capture MISO on the same edge.
               if (wrap_s) begin
                  state_r <= ST_HIGH;
                  sclk_r  <= 1'b1;
                  rx_sh_r <= {rx_sh_r[6:0], spi_rx};
               end
            end
            ST_HIGH: begin
               // Falling SCLK: advance MOSI, or close out a completed byte.
               if (wrap_s) begin
                  state_r <= ST_LOW;
                  sclk_r  <= 1'b0;
                  if (bit_r == 3'd7) begin
                     bit_r              <= 3'd0;
                     rx_r[byte_r[1:0]]  <= rx_sh_r;
                     byte_r             <= nxt_byte_s;
                     if (nxt_byte_s == len_r) begin
                        // Last byte: this low phase doubles as the CS trail time.
                        state_r <= ST_TRAIL;
                        mosi_r  <= 1'b0;
                     end else begin
                        tx_sh_r <= tx_l_r[nxt_byte_s[1:0]];
                        mosi_r  <= tx_l_r[nxt_byte_s[1:0]][7];
                     end
                  end else begin
                     bit_r   <= bit_r + 3'd1;
                     tx_sh_r <= {tx_sh_r[6:0], 1'b0};
                     mosi_r  <= tx_sh_r[6];
                  end
               end
            end
            ST_TRAIL: begin
               if (wrap_s) begin
                  state_r <= ST_IDLE;
                  cs_n_r  <= 1'b1;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               cs_n_r  <= 1'b1;
               sclk_r  <= 1'b0;
               mosi_r  <= 1'b0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rx   = rx_r;
   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign spi_sclk = sclk_r;
   assign spi_cs_n = cs_n_r;
   assign spi_tx   = mosi_r;

endmodule

// File: tb/tb_spi_master_buffer.sv
// tb_spi_master_buffer
// Scoreboarded bench: one CLK_DIV=2 instance (loopback or target model on
// MISO) and one CLK_DIV=1 instance (loopback). Expected frames are queued at
// launch and compared when done pulses.
module tb_spi_master_buffer;

   typedef struct {
      logic [3:0][7:0] rx;
      int              cs;
      int              rises;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset2, reset1;
   logic sclk2, cs2_n, mosi2, miso2;
   logic sclk1, cs1_n, mosi1;
   logic loop2;

   spi_master_buffer_if bus2();
   spi_master_buffer_if bus1();

   spi_master_buffer #(.CLK_DIV(2)) dut2 (
      .clk(clk), .reset(reset2), .bus(bus2),
      .spi_sclk(sclk2), .spi_cs_n(cs2_n), .spi_tx(mosi2), .spi_rx(miso2));

   spi_master_buffer #(.CLK_DIV(1)) dut1 (
      .clk(clk), .reset(reset1), .bus(bus1),
      .spi_sclk(sclk1), .spi_cs_n(cs1_n), .spi_tx(mosi1), .spi_rx(mosi1));

   // target model state
   logic [7:0] tgt_resp [4];
   logic [7:0] tgt_seen [4];
   logic [7:0] tgt_out = 8'h00;
   logic [7:0] tgt_in  = 8'h00;
   int         tgt_bits = 0;

   assign miso2 = loop2 ? mosi2 : tgt_out[7];

   // monitors
   int cs_low2 = 0, rise2 = 0, done2 = 0, busy_cyc2 = 0;
   int mode_viol2 = 0, busy_viol2 = 0, rx_viol2 = 0;
   int cs_low1 = 0, rise1 = 0, done1 = 0, tog1 = 0;
   int mode_viol1 = 0, busy_viol1 = 0;
   logic sclk2_q = 1'b0, cs2_q = 1'b1, mosi2_q = 1'b0, busy2_q = 1'b0, reset2_q = 1'b1;
   logic sclk1_q = 1'b0, cs1_q = 1'b1, mosi1_q = 1'b0;
   logic [3:0][7:0] rx2_q = 32'h0;

   int checks = 0;
   int errors = 0;
   exp_t exp_q2[$];
   exp_t exp_q1[$];
   logic [3:0][7:0] rx_model2 = 32'h0;
   logic [3:0][7:0] rx_model1 = 32'h0;

   always @(negedge clk) begin
      sclk2_q <= sclk2; cs2_q <= cs2_n; mosi2_q <= mosi2;
      busy2_q <= bus2.busy; reset2_q <= reset2; rx2_q <= bus2.rx;
      if (!cs2_n) cs_low2 <= cs_low2 + 1;
      if (sclk2 && !sclk2_q) rise2 <= rise2 + 1;
      if (bus2.done) done2 <= done2 + 1;
      if (bus2.busy) busy_cyc2 <= busy_cyc2 + 1;
      if (!cs2_n && !cs2_q && (mosi2 != mosi2_q) && !(sclk2_q && !sclk2)) mode_viol2 <= mode_viol2 + 1;
      if (bus2.busy == cs2_n) busy_viol2 <= busy_viol2 + 1;
      if (!reset2 && !reset2_q && !bus2.busy && !busy2_q && (bus2.rx != rx2_q)) rx_viol2 <= rx_viol2 + 1;
      // mode-0 target: shift in on SCLK rise, shift out on SCLK fall
      if (cs2_q && !cs2_n) begin
         tgt_bits <= 0;
         tgt_out  <= tgt_resp[0];
      end else if (!cs2_n) begin
         if (sclk2 && !sclk2_q) begin
            tgt_in   <= {tgt_in[6:0], mosi2};
            tgt_bits <= tgt_bits + 1;
            if (((tgt_bits + 1) % 8) == 0) tgt_seen[(tgt_bits / 8) % 4] <= {tgt_in[6:0], mosi2};
         end else if (!sclk2 && sclk2_q) begin
            if ((tgt_bits % 8) == 0) tgt_out <= tgt_resp[(tgt_bits / 8) % 4];
            else tgt_out <= {tgt_out[6:0], 1'b0};
         end
      end
      sclk1_q <= sclk1; cs1_q <= cs1_n; mosi1_q <= mosi1;
      if (!cs1_n) cs_low1 <= cs_low1 + 1;
      if (sclk1 && !sclk1_q) rise1 <= rise1 + 1;
      if (sclk1 != sclk1_q) tog1 <= tog1 + 1;
      if (bus1.done) done1 <= done1 + 1;
      if (!cs1_n && !cs1_q && (mosi1 != mosi1_q) && !(sclk1_q && !sclk1)) mode_viol1 <= mode_viol1 + 1;
      if (bus1.busy == cs1_n) busy_viol1 <= busy_viol1 + 1;
   end

   task automatic launch2(input logic [3:0][7:0] t, input logic [2:0] l);
      @(posedge clk); #1;
      bus2.tx = t; bus2.length = l; bus2.start = 1'b1;
      @(posedge clk); #1;
      bus2.start = 1'b0;
   endtask

   task automatic launch1(input logic [3:0][7:0] t, input logic [2:0] l);
      @(posedge clk); #1;
      bus1.tx = t; bus1.length = l; bus1.start = 1'b1;
      @(posedge clk); #1;
      bus1.start = 1'b0;
   endtask

   task automatic wait_done2(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus2.done === 1'b1) begin ok = 1'b1; break; end
      end
      #1;
   endtask

   task automatic wait_done1(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus1.done === 1'b1) begin ok = 1'b1; break; end
      end
      #1;
   endtask

   task automatic test_reset();
      #12;
      checks++; if (cs2_n !== 1'b1) begin errors++; $display("FAIL reset_cs actual %b required 1", cs2_n); end
      checks++; if (sclk2 !== 1'b0) begin errors++; $display("FAIL reset_sclk actual %b required 0", sclk2); end
      checks++; if (mosi2 !== 1'b0) begin errors++; $display("FAIL reset_mosi actual %b required 0", mosi2); end
      checks++; if (bus2.busy !== 1'b0 || bus2.done !== 1'b0) begin errors++; $display("FAIL reset_busy_done actual %b%b required 00", bus2.busy, bus2.done); end
      checks++; if (bus2.rx !== 32'h0) begin errors++; $display("FAIL reset_rx actual %h required 0", bus2.rx); end
      checks++; if (cs1_n !== 1'b1 || bus1.busy !== 1'b0) begin errors++; $display("FAIL reset_dut1 actual cs=%b busy=%b required cs=1 busy=0", cs1_n, bus1.busy); end
      @(negedge clk);
      reset2 = 1'b0; reset1 = 1'b0;
   endtask

   task automatic test_loopback();
      exp_t e; bit ok; int c0, r0, d0;
      loop2 = 1'b1;
      c0 = cs_low2; r0 = rise2; d0 = done2;
      rx_model2[0] = 8'hA5;
      e.rx = rx_model2; e.cs = 34; e.rises = 8; exp_q2.push_back(e);
      launch2(32'h000000A5, 3'd1);
      wait_done2(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL loop_timeout actual none required done"); end
      e = exp_q2.pop_front();
      checks++; if (bus2.rx !== e.rx) begin errors++; $display("FAIL loop_rx actual %h required %h", bus2.rx, e.rx); end
      checks++; if (cs_low2 - c0 != e.cs) begin errors++; $display("FAIL loop_cs actual %0d required %0d", cs_low2 - c0, e.cs); end
      checks++; if (rise2 - r0 != e.rises) begin errors++; $display("FAIL loop_rises actual %0d required %0d", rise2 - r0, e.rises); end
      checks++; if (done2 - d0 != 1) begin errors++; $display("FAIL loop_done actual %0d required 1", done2 - d0); end
      checks++; if (bus2.busy !== 1'b0 || cs2_n !== 1'b1) begin errors++; $display("FAIL loop_busy_cs actual busy=%b cs=%b required busy=0 cs=1", bus2.busy, cs2_n); end
   endtask

   task automatic test_four_byte();
      exp_t e; bit ok; int c0, r0;
      logic [31:0] seen;
      loop2 = 1'b0;
      tgt_resp[0] = 8'h3C; tgt_resp[1] = 8'h81; tgt_resp[2] = 8'h00; tgt_resp[3] = 8'hFF;
      c0 = cs_low2; r0 = rise2;
      rx_model2 = 32'hFF00813C;
      e.rx = rx_model2; e.cs = 130; e.rises = 32; exp_q2.push_back(e);
      launch2(32'h78563412, 3'd4);
      wait_done2(400, ok);
      checks++; if (!ok) begin errors++; $display("FAIL four_timeout actual none required done"); end
      e = exp_q2.pop_front();
      checks++; if (bus2.rx !== e.rx) begin errors++; $display("FAIL four_rx actual %h required %h", bus2.rx, e.rx); end
      checks++; if (cs_low2 - c0 != e.cs) begin errors++; $display("FAIL four_cs actual %0d required %0d", cs_low2 - c0, e.cs); end
      checks++; if (rise2 - r0 != e.rises) begin errors++; $display("FAIL four_rises actual %0d required %0d", rise2 - r0, e.rises); end
      seen = {tgt_seen[3], tgt_seen[2], tgt_seen[1], tgt_seen[0]};
      checks++; if (seen !== 32'h78563412) begin errors++; $display("FAIL four_mosi actual %h required 78563412", seen); end
      loop2 = 1'b1;
   endtask

   task automatic test_start_while_busy();
      exp_t e; bit ok; int c0, r0, d0;
      loop2 = 1'b1;
      c0 = cs_low2; r0 = rise2; d0 = done2;
      rx_model2[0] = 8'hC3; rx_model2[1] = 8'h11;
      e.rx = rx_model2; e.cs = 66; e.rises = 16; exp_q2.push_back(e);
      launch2(32'h000011C3, 3'd2);
      repeat (10) @(posedge clk);
      launch2(32'hFFFFFFFF, 3'd4);
      wait_done2(400, ok);
      checks++; if (!ok) begin errors++; $display("FAIL busy_timeout actual none required done"); end
      e = exp_q2.pop_front();
      checks++; if (bus2.rx !== e.rx) begin errors++; $display("FAIL busy_rx actual %h required %h", bus2.rx, e.rx); end
      checks++; if (cs_low2 - c0 != e.cs) begin errors++; $display("FAIL busy_cs actual %0d required %0d", cs_low2 - c0, e.cs); end
      checks++; if (done2 - d0 != 1) begin errors++; $display("FAIL busy_done actual %0d required 1", done2 - d0); end
      // start in the done cycle
      c0 = cs_low2; r0 = rise2; d0 = done2;
      rx_model2[0] = 8'h7E;
      e.rx = rx_model2; e.cs = 34; e.rises = 8; exp_q2.push_back(e);
      bus2.tx = 32'h0000007E; bus2.length = 3'd1; bus2.start = 1'b1;
      @(posedge clk); #1;
      bus2.start = 1'b0;
      checks++; if (bus2.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy actual %b required 1", bus2.busy); end
      wait_done2(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout actual none required done"); end
      e = exp_q2.pop_front();
      checks++; if (bus2.rx !== e.rx) begin errors++; $display("FAIL b2b_rx actual %h required %h", bus2.rx, e.rx); end
      checks++; if (cs_low2 - c0 != e.cs) begin errors++; $display("FAIL b2b_cs actual %0d required %0d", cs_low2 - c0, e.cs); end
      checks++; if (rise2 - r0 != e.rises) begin errors++; $display("FAIL b2b_rises actual %0d required %0d", rise2 - r0, e.rises); end
   endtask

   task automatic test_length_edges();
      exp_t e; bit ok; int c0, r0, d0, b0;
      loop2 = 1'b1;
      c0 = cs_low2; d0 = done2; b0 = busy_cyc2;
      launch2(32'hDEADBEEF, 3'd0);
      repeat (40) @(negedge clk);
      #1;
      checks++; if (cs_low2 - c0 != 0) begin errors++; $display("FAIL len0_cs actual %0d required 0", cs_low2 - c0); end
      checks++; if (done2 - d0 != 0) begin errors++; $display("FAIL len0_done actual %0d required 0", done2 - d0); end
      checks++; if (busy_cyc2 - b0 != 0) begin errors++; $display("FAIL len0_busy actual %0d required 0", busy_cyc2 - b0); end
      c0 = cs_low2; r0 = rise2;
      rx_model2 = 32'hC0FFEE11;
      e.rx = rx_model2; e.cs = 130; e.rises = 32; exp_q2.push_back(e);
      launch2(32'hC0FFEE11, 3'd6);
      wait_done2(400, ok);
      checks++; if (!ok) begin errors++; $display("FAIL len6_timeout actual none required done"); end
      e = exp_q2.pop_front();
      checks++; if (bus2.rx !== e.rx) begin errors++; $display("FAIL len6_rx actual %h required %h", bus2.rx, e.rx); end
      checks++; if (cs_low2 - c0 != e.cs) begin errors++; $display("FAIL len6_cs actual %0d required %0d", cs_low2 - c0, e.cs); end
      checks++; if (rise2 - r0 != e.rises) begin errors++; $display("FAIL len6_rises actual %0d required %0d", rise2 - r0, e.rises); end
   endtask

   task automatic test_reset_mid();
      exp_t e; bit ok; int c0, r0, d0;
      loop2 = 1'b1;
      r0 = rise2; d0 = done2; ok = 1'b0;
      launch2(32'h44332211, 3'd4);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (rise2 - r0 >= 3) begin ok = 1'b1; break; end
      end
      checks++; if (!ok) begin errors++; $display("FAIL rmid_rises actual %0d required 3", rise2 - r0); end
      reset2 = 1'b1;
      #1;
      checks++; if (cs2_n !== 1'b1 || sclk2 !== 1'b0) begin errors++; $display("FAIL rmid_pins actual cs=%b sclk=%b required cs=1 sclk=0", cs2_n, sclk2); end
      checks++; if (bus2.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy actual %b required 0", bus2.busy); end
      checks++; if (bus2.rx !== 32'h0) begin errors++; $display("FAIL rmid_rx actual %h required 0", bus2.rx); end
      rx_model2 = 32'h0;
      repeat (3) @(negedge clk);
      reset2 = 1'b0;
      repeat (40) @(negedge clk);
      #1;
      checks++; if (done2 - d0 != 0) begin errors++; $display("FAIL rmid_done actual %0d required 0", done2 - d0); end
      c0 = cs_low2; r0 = rise2;
      rx_model2[0] = 8'h96;
      e.rx = rx_model2; e.cs = 34; e.rises = 8; exp_q2.push_back(e);
      launch2(32'h00000096, 3'd1);
      wait_done2(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rpost_timeout actual none required done"); end
      e = exp_q2.pop_front();
      checks++; if (bus2.rx !== e.rx) begin errors++; $display("FAIL rpost_rx actual %h required %h", bus2.rx, e.rx); end
      checks++; if (cs_low2 - c0 != e.cs) begin errors++; $display("FAIL rpost_cs actual %0d required %0d", cs_low2 - c0, e.cs); end
   endtask

   task automatic test_clkdiv1();
      exp_t e; bit ok; int c0, r0, d0, t0;
      c0 = cs_low1; r0 = rise1; d0 = done1; t0 = tog1;
      rx_model1[0] = 8'h5A; rx_model1[1] = 8'h5A;
      e.rx = rx_model1; e.cs = 33; e.rises = 16; exp_q1.push_back(e);
      launch1(32'h00005A5A, 3'd2);
      wait_done1(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL div1_timeout actual none required done"); end
      e = exp_q1.pop_front();
      checks++; if (bus1.rx !== e.rx) begin errors++; $display("FAIL div1_rx actual %h required %h", bus1.rx, e.rx); end
      checks++; if (cs_low1 - c0 != e.cs) begin errors++; $display("FAIL div1_cs actual %0d required %0d", cs_low1 - c0, e.cs); end
      checks++; if (rise1 - r0 != e.rises) begin errors++; $display("FAIL div1_rises actual %0d required %0d", rise1 - r0, e.rises); end
      checks++; if (tog1 - t0 != 32) begin errors++; $display("FAIL div1_toggles actual %0d required 32", tog1 - t0); end
      checks++; if (done1 - d0 != 1) begin errors++; $display("FAIL div1_done actual %0d required 1", done1 - d0); end
   endtask

   initial begin
      reset2 = 1'b1; reset1 = 1'b1; loop2 = 1'b1;
      bus2.start = 1'b0; bus2.length = 3'd0; bus2.tx = 32'h0;
      bus1.start = 1'b0; bus1.length = 3'd0; bus1.tx = 32'h0;
      for (int i = 0; i < 4; i++) tgt_resp[i] = 8'h00;
      test_reset();
      test_loopback();
      test_four_byte();
      test_start_while_busy();
      test_length_edges();
      test_reset_mid();
      test_clkdiv1();
      repeat (3) @(negedge clk);
      #1;
      checks++; if (mode_viol2 != 0 || mode_viol1 != 0) begin errors++; $display("FAIL mosi_timing actual %0d/%0d required 0/0", mode_viol2, mode_viol1); end
      checks++; if (busy_viol2 != 0 || busy_viol1 != 0) begin errors++; $display("FAIL busy_vs_cs actual %0d/%0d required 0/0", busy_viol2, busy_viol1); end
      checks++; if (rx_viol2 != 0) begin errors++; $display("FAIL rx_stable actual %0d required 0", rx_viol2); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_master_buffer.md
Name: spi_master_buffer

Overview:
- SPI initiator (mode 0, MSB first) that clocks out a frame of 1-4 bytes while capturing the same number of response bytes.
- It is the controller-side counterpart of the team's SPI target buffer. It runs in the FPGA clock domain and generates spi_sclk/spi_cs_n itself.
- A parent FSM loads the tx bytes and length, pulses start, waits for done, then reads rx.

Parameters:
- CLK_DIV, 2, clk cycles per SCLK half-period (legal range >= 1). Resulting SCLK frequency is clk / (2*CLK_DIV).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request; accepted only while idle.
- tx  input  [7:0] x4  bytes to send; tx[0] is sent first. Latched on accepted start.
- length  input  3  byte count; latched on accepted start.
- rx  output reg  [7:0] x4  received bytes; rx[i] is written when byte i completes.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse marking the end of the frame.
- spi_sclk  output  1  SPI clock; idles low.
- spi_cs_n  output  1  chip select, active low; idles high.
- spi_tx  output  1  MOSI.
- spi_rx  input  1  MISO; this block does not synchronise it.

Behaviour:
- Reset (async assert):
  - State goes to IDLE.
  - spi_cs_n=1, spi_sclk=0, spi_tx=0, busy=0, done=0.
  - rx[0..3]=0; byte index and bit index = 0.
  - Reset mid-frame aborts the frame immediately: CS deasserts with no done pulse and partial rx is cleared.
- Length handling:
  - length 0: start is ignored (no busy, no CS, no done).
  - length 5-7: treated as 4.
- Start while busy is ignored and the latched tx/length are not disturbed.
- States: IDLE, LEAD, HIGH, LOW, TRAIL.
  - A half-period counter runs from 0 to CLK_DIV-1. Each state ends when the counter wraps.
- IDLE + valid start (edge k):
  - At edge k: spi_cs_n=0, busy=1, spi_tx=tx[0][7]; enter LEAD.
- LEAD: CS low and SCLK low for CLK_DIV cycles, then enter HIGH.
- HIGH:
  - On entry: spi_sclk=1, and spi_rx is shifted into the rx shift register (LSB in).
  - Holds for CLK_DIV cycles, then enters LOW.
- LOW:
  - On entry: spi_sclk=0 and the bit index increments.
  - If the bit index is < 8: spi_tx is driven with the next tx bit on that same edge.
  - If the 8th bit is complete:
    - rx[byte] is written with the shift register and byte++.
    - If byte == length, enter TRAIL after CLK_DIV cycles. Otherwise spi_tx = tx[byte][7] and the bit cycle continues.
  - Holds for CLK_DIV cycles, then enters HIGH (next bit).
- TRAIL:
  - CS is held low with SCLK low for CLK_DIV cycles.
  - Then spi_cs_n=1, busy=0 and done=1 for exactly one cycle; return to IDLE.
- A new start is accepted in the cycle done is high or any later cycle.
- Timing for N bytes:
  - spi_cs_n is low for exactly (16N+1)*CLK_DIV clk cycles.
  - Exactly 8N rising SCLK edges occur.
  - done asserts at edge k + (16N+1)*CLK_DIV.
- Mode 0 timing: MOSI changes only on SCLK falling edges (or at CS assert); MISO is sampled on SCLK rising edges.
- rx contents:
  - rx[i] for i >= N keeps its prior value.
  - rx is stable whenever busy=0.

Test Plan:
- Loopback, CLK_DIV=2 (spi_rx tied to spi_tx): tx[0]=0xA5, length=1, start -> CS low 34 cycles, 8 SCLK pulses, rx[0]=0xA5, one done pulse, busy falls when CS rises.
- Four-byte frame with a target model returning 0x3C,0x81,0x00,0xFF; tx=0x12,0x34,0x56,0x78 -> target sees MOSI 12 34 56 78 MSB first; rx={3C,81,00,FF}; 32 SCLK rises; CS low 130 cycles.
- Start while busy: start pulsed mid-frame with different tx/length -> frame unchanged, exactly one done; a start in the done cycle launches a second frame.
- Length edge cases: length=0 -> no CS activity, no done, busy stays 0; length=6 -> behaves as 4 (CS low 130 cycles at CLK_DIV=2).
- Reset mid-frame: assert reset after 3 SCLK rises -> spi_cs_n=1, spi_sclk=0, busy=0 asynchronously; rx all 0; no done. A subsequent start performs a normal frame.
- CLK_DIV=1 build, loopback 0x5A, length=2 -> SCLK toggles every clk, CS low 33 cycles, rx[0]=rx[1]=0x5A.
